boot_rom_ctrl: RTL and testbench

Parametrised boot ROM controller for the SoC boot path: a pipelined request/grant/rvalid slave in front of a ROM word array.
- Configurable data width, depth and read latency.
- Out-of-range error responses.
- Sticky post-boot lockout that blocks ROM reads once the boot code has handed off.
- Sits on the SoC interconnect where the single-cycle boot ROM macro sat; the array itself is a sub-module.

---
 rtl/boot_rom_pkg.sv | 55 +++++
 rtl/boot_rom_array.sv | 64 ++++++
 rtl/boot_rom_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_boot_rom_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_rom_pkg.sv
// -----------------------------------------------------------------------------
// boot_rom_pkg
// Shared types and helpers for the boot ROM controller and its word array.
//   - rom_resp_t     : one pipeline slot {valid, err, data}, sized for the
//                      widest legal word (64 bits); narrower builds use the
//                      low DATA_WIDTH bits.
//   - patch_entry_t  : one patch table entry {valid, word address, data}.
//   - Legality checks for DATA_WIDTH and READ_LATENCY.
//   - Width helpers for the byte-offset field and the top of the word index.
//   - rom_pattern    : built-in word contents of the generic array model.
// -----------------------------------------------------------------------------
package boot_rom_pkg;

   localparam int MAX_DATA_WIDTH = 64;
   localparam int MAX_ADDR_WIDTH = 64;

   typedef struct packed {
      logic                      valid;
      logic                      err;
      logic [MAX_DATA_WIDTH-1:0] data;
   } rom_resp_t;

   typedef struct packed {
      logic                      valid;
      logic [MAX_ADDR_WIDTH-1:0] word_addr;
      logic [MAX_DATA_WIDTH-1:0] data;
   } patch_entry_t;

   function automatic bit data_width_legal(input int dw);
      return (dw == 32) || (dw == 64);
   endfunction

   function automatic bit read_latency_legal(input int lat);
      return (lat >= 1) && (lat <= 4);
   endfunction

   // Number of byte-offset bits below the word index.
   function automatic int off_width(input int dw);
      return $clog2(dw / 8);
   endfunction

   // One past the most significant word-index bit of the byte address.
   function automatic int idx_top(input int depth, input int dw);
      return $clog2(depth * (dw / 8));
   endfunction

   // Word i holds {i ^ 16'hB007, i} in its low 32 bits; 64-bit words carry
   // the bitwise complement of that in their upper half.
   function automatic logic [MAX_DATA_WIDTH-1:0] rom_pattern(input logic [15:0] idx);
      logic [31:0] lo;
      lo = {idx ^ 16'hB007, idx};
      return {~lo, lo};
   endfunction

endpackage

// File: rtl/boot_rom_array.sv
// -----------------------------------------------------------------------------
// boot_rom_array
// Synchronous single-port ROM, one cycle from enable to q_o.
//   clk_i   : clock
//   en_i    : read enable; q_o updates only on enabled cycles
//   addr_i  : word index
//   q_o     : read word
// Macros:
//   PULP_FPGA_EMUL : use the vendor sprom macro, loaded from INIT_FILE.
//   (undefined)    : generic model whose contents are rom_pattern(); the
//                    hardening flow swaps in the real macro.
// -----------------------------------------------------------------------------
module boot_rom_array
   import boot_rom_pkg::*;
#(
   parameter int    DATA_WIDTH = 32,
   parameter int    ROM_DEPTH  = 2048,
   parameter int    IDX_WIDTH  = 11,
   parameter string INIT_FILE  = "none"
) (
   input  logic                  clk_i,
   input  logic                  en_i,
   input  logic [IDX_WIDTH-1:0]  addr_i,
   output logic [DATA_WIDTH-1:0] q_o
);

`ifdef PULP_FPGA_EMUL
   sprom #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (IDX_WIDTH),
      .DEPTH      (ROM_DEPTH),
      .INIT_FILE  (INIT_FILE)
   ) i_sprom (
      .clk  (clk_i),
      .en   (en_i),
      .addr (addr_i),
      .q    (q_o)
   );
`else
   logic [DATA_WIDTH-1:0] r_q;

   // NOTE: sequential state is always written with <= so every flop samples
   // the pre-edge value of its inputs, independent of block ordering.
   // NOTE: the read register is deliberately not reset: like a real ROM
   // macro it has no reset pin, and the controller qualifies it with its own
   // cleared valid bits.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         r_q <= DATA_WIDTH'(rom_pattern(16'(addr_i)));
      end
   end

   assign q_o = r_q;

   // The generic model only carries the built-in pattern.
   always_ff @(posedge clk_i) begin
      assert (INIT_FILE == "none")
         else $error("boot_rom_array: generic model cannot load an init file");
      assert (ROM_DEPTH <= (2 ** IDX_WIDTH))
         else $error("boot_rom_array: ROM_DEPTH exceeds index range");
   end
`endif

endmodule

// File: rtl/boot_rom_ctrl.sv
// -----------------------------------------------------------------------------
// boot_rom_ctrl
// Pipelined req/gnt/rvalid slave in front of the boot ROM array, with
// out-of-range error responses and a sticky post-boot lockout.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   req_i, addr_i  : read request and byte address; always granted (gnt_o)
//   rvalid_o       : response valid, READ_LATENCY cycles after the grant
//   rdata_o, err_o : response word (0 on error or idle) and error flag
//   lock_i         : lock request pulse; locked_o is sticky until reset
//   test_mode_i    : DFT override, lockout ignored while high
//   patch_*        : patch table write port (BOOT_ROM_PATCH_EN only)
// Macros:
//   BOOT_ROM_PATCH_EN : NUM_PATCH-entry patch table overriding array words.
// -----------------------------------------------------------------------------
module boot_rom_ctrl
   import boot_rom_pkg::*;
#(
   parameter int    DATA_WIDTH   = 32,
   parameter int    ROM_DEPTH    = 2048,
   parameter int    ADDR_WIDTH   = 32,
   parameter int    READ_LATENCY = 1,
   parameter string INIT_FILE    = "none",
   parameter int    NUM_PATCH    = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic                  gnt_o,
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  err_o,
   input  logic                  lock_i,
   output logic                  locked_o,
   input  logic                  test_mode_i
`ifdef BOOT_ROM_PATCH_EN
   ,
   input  logic                         patch_we_i,
   input  logic [$clog2(NUM_PATCH)-1:0] patch_idx_i,
   input  logic [ADDR_WIDTH-1:0]        patch_addr_i,
   input  logic [DATA_WIDTH-1:0]        patch_data_i
`endif
);

   localparam int OFF_W = off_width(DATA_WIDTH);
   localparam int TOP   = idx_top(ROM_DEPTH, DATA_WIDTH);
   localparam int IDX_W = TOP - OFF_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROM_DEPTH - 1);

   logic                  w_gnt;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_range_err;
   logic                  w_err;
   logic                  w_arr_en;
   logic [DATA_WIDTH-1:0] w_arr_q;
   logic                  w_unused_offset;
   logic                  w_unused_data;

   logic                  r_locked;
   logic                  r_s0_valid;
   logic                  r_s0_err;

   rom_resp_t             w_s0;
   rom_resp_t             w_out;

   // ---------------------------------------------------------------- checks
   always_ff @(posedge clk_i) begin
      assert (data_width_legal(DATA_WIDTH))
         else $error("boot_rom_ctrl: DATA_WIDTH must be 32 or 64");
      assert (read_latency_legal(READ_LATENCY))
         else $error("boot_rom_ctrl: READ_LATENCY must be 1..4");
      assert (TOP < ADDR_WIDTH)
         else $error("boot_rom_ctrl: ROM does not fit below ADDR_WIDTH");
      assert (NUM_PATCH >= 2)
         else $error("boot_rom_ctrl: NUM_PATCH must be at least 2");
   end

   // ------------------------------------------------------- request decode
   assign w_gnt       = req_i & ~rst_i;
   assign w_idx       = addr_i[TOP-1:OFF_W];
   // Non-power-of-two depths leave a hole at the top of the index field;
   // address bits above the field are never a valid ROM location.
   assign w_range_err = (|addr_i[ADDR_WIDTH-1:TOP]) | (w_idx > LAST_IDX);
   assign w_err       = w_range_err | (r_locked & ~test_mode_i);
   // The array only sees accesses that will return data.
   assign w_arr_en    = w_gnt & ~w_err;

   // Byte-offset bits carry no meaning for a word-wide ROM.
   assign w_unused_offset = ^addr_i[OFF_W-1:0];

   // ---------------------------------------------------------------- lockout
   // lock_i takes effect from the next cycle, so a grant in the lock cycle
   // still sees r_locked low and is served.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_locked <= 1'b0;
      end else if (lock_i) begin
         r_locked <= 1'b1;
      end
   end

   // ------------------------------------------------------------ word array
   boot_rom_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROM_DEPTH  (ROM_DEPTH),
      .IDX_WIDTH  (IDX_W),
      .INIT_FILE  (INIT_FILE)
   ) u_array (
      .clk_i  (clk_i),
      .en_i   (w_arr_en),
      .addr_i (w_idx),
      .q_o    (w_arr_q)
   );

   // ------------------------------------------------------------ patch table
`ifdef BOOT_ROM_PATCH_EN
   patch_entry_t          r_patch [NUM_PATCH];
   logic                  w_phit;
   logic [DATA_WIDTH-1:0] w_pdata;
   logic                  r_s0_phit;
   logic [DATA_WIDTH-1:0] r_s0_pdata;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_PATCH; i++) begin
            r_patch[i].valid <= 1'b0;
         end
      end else if (patch_we_i && !r_locked && (int'(patch_idx_i) < NUM_PATCH)) begin
         r_patch[patch_idx_i].valid     <= 1'b1;
         r_patch[patch_idx_i].word_addr <= MAX_ADDR_WIDTH'(patch_addr_i >> OFF_W);
         r_patch[patch_idx_i].data      <= MAX_DATA_WIDTH'(patch_data_i);
      end
   end

   // Scanned from the top so the lowest matching index is the last writer.
   always_comb begin
      w_phit  = 1'b0;
      w_pdata = '0;
      for (int i = NUM_PATCH - 1; i >= 0; i--) begin
         if (r_patch[i].valid &&
             (r_patch[i].word_addr == MAX_ADDR_WIDTH'(addr_i >> OFF_W))) begin
            w_phit  = 1'b1;
            w_pdata = DATA_WIDTH'(r_patch[i].data);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      r_s0_phit  <= w_phit & w_arr_en;
      r_s0_pdata <= w_pdata;
   end
`endif

   // ------------------------------------------------------ stage 0 (array)
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s0_valid <= 1'b0;
         r_s0_err   <= 1'b0;
      end else begin
         r_s0_valid <= w_gnt;
         r_s0_err   <= w_err;
      end
   end

   // NOTE: every field gets a default before the conditional updates, so no
   // path through this block leaves a bit unassigned and no latch is inferred.
   always_comb begin
      w_s0       = '0;
      w_s0.valid = r_s0_valid;
      w_s0.err   = r_s0_err;
      if (r_s0_valid && !r_s0_err) begin
`ifdef BOOT_ROM_PATCH_EN
         w_s0.data = r_s0_phit ? MAX_DATA_WIDTH'(r_s0_pdata)
                               : MAX_DATA_WIDTH'(w_arr_q);
`else
         w_s0.data = MAX_DATA_WIDTH'(w_arr_q);
`endif
      end
   end

   // ------------------------------------------------- delay stages 1..L-1
   generate
      if (READ_LATENCY > 1) begin : g_pipe
         rom_resp_t r_pipe [1:READ_LATENCY-1];

         // Data shifts unconditionally; reset only has to kill valid/err,
         // which the later assignments below override.
         always_ff @(posedge clk_i) begin
            r_pipe[1] <= w_s0;
            for (int i = 2; i < READ_LATENCY; i++) begin
               r_pipe[i] <= r_pipe[i-1];
            end
            if (rst_i) begin
               for (int i = 1; i < READ_LATENCY; i++) begin
                  r_pipe[i].valid <= 1'b0;
                  r_pipe[i].err   <= 1'b0;
               end
            end
         end

         assign w_out = r_pipe[READ_LATENCY-1];
      end else begin : g_no_pipe
         assign w_out = w_s0;
      end
   endgenerate

   // --------------------------------------------------------------- outputs
   assign gnt_o    = w_gnt;
   assign rvalid_o = w_out.valid;
   assign err_o    = w_out.valid & w_out.err;
   assign rdata_o  = w_out.valid ? DATA_WIDTH'(w_out.data) : '0;
   assign locked_o = r_locked;

   // Upper bits of the max-width slot are don't-care for 32-bit builds.
   assign w_unused_data = ^w_out.data;

endmodule

// File: tb/tb_boot_rom_ctrl.sv
// -----------------------------------------------------------------------------
// tb_boot_rom_ctrl
// Three controllers share one stimulus stream:
//   k0 : ROM_DEPTH 2048, READ_LATENCY 1
//   k1 : ROM_DEPTH 1000, READ_LATENCY 3
//   k2 : ROM_DEPTH 2048, READ_LATENCY 4
// A transaction-level model predicts, per controller, a queue of responses
// with their due cycle; a negedge process compares every cycle. Directed
// literal checks pin the model on the interesting cases.
// Define BOOT_ROM_PATCH_EN to exercise the patch table.
// -----------------------------------------------------------------------------
module tb_boot_rom_ctrl;

   localparam int NI = 3;
   localparam logic [NI-1:0][15:0] DEPTH = {16'd2048, 16'd1000, 16'd2048};
   localparam logic [NI-1:0][2:0]  LAT   = {3'd4, 3'd3, 3'd1};

   logic                 clk_i       = 1'b0;
   logic                 rst_i       = 1'b1;
   logic                 req_i       = 1'b0;
   logic [31:0]          addr_i      = '0;
   logic                 lock_i      = 1'b0;
   logic                 test_mode_i = 1'b0;
   logic [NI-1:0]        gnt;
   logic [NI-1:0]        rvalid;
   logic [NI-1:0]        err;
   logic [NI-1:0]        locked;
   logic [NI-1:0][31:0]  rdata;
`ifdef BOOT_ROM_PATCH_EN
   logic                 patch_we_i   = 1'b0;
   logic [1:0]           patch_idx_i  = '0;
   logic [31:0]          patch_addr_i = '0;
   logic [31:0]          patch_data_i = '0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      boot_rom_ctrl #(
         .DATA_WIDTH   (32),
         .ROM_DEPTH    (int'(DEPTH[k])),
         .ADDR_WIDTH   (32),
         .READ_LATENCY (int'(LAT[k])),
         .INIT_FILE    ("none"),
         .NUM_PATCH    (4)
      ) u_dut (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .req_i        (req_i),
         .addr_i       (addr_i),
         .gnt_o        (gnt[k]),
         .rvalid_o     (rvalid[k]),
         .rdata_o      (rdata[k]),
         .err_o        (err[k]),
         .lock_i       (lock_i),
         .locked_o     (locked[k]),
         .test_mode_i  (test_mode_i)
`ifdef BOOT_ROM_PATCH_EN
         ,
         .patch_we_i   (patch_we_i),
         .patch_idx_i  (patch_idx_i),
         .patch_addr_i (patch_addr_i),
         .patch_data_i (patch_data_i)
`endif
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ROM contents: word i holds {i ^ 0xB007, i} in its 16-bit halves.
   function automatic logic [31:0] rom_word(input logic [31:0] w);
      logic [15:0] lo;
      lo = w[15:0];
      return {lo ^ 16'hB007, lo};
   endfunction

   // ------------------------------------------------------------------ model
   typedef struct {
      int unsigned due;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q [NI][$];
   int unsigned cyc      = 0;
   logic        m_locked = 1'b0;
   exp_t        m_e;
`ifdef BOOT_ROM_PATCH_EN
   logic        p_valid [4] = '{default: 1'b0};
   logic [31:0] p_addr  [4];
   logic [31:0] p_data  [4];
`endif

   always @(posedge clk_i) begin
      cyc++;
      for (int k = 0; k < NI; k++) begin
         if (rst_i) begin
            exp_q[k].delete();
         end else if (req_i) begin
            m_e.due  = cyc + int'(LAT[k]) - 1;
            // Any word number at or past the depth is out of range; that
            // also covers every address with bits above the ROM window.
            m_e.err  = ((addr_i >> 2) >= 32'(DEPTH[k])) || (m_locked && !test_mode_i);
            m_e.data = m_e.err ? 32'h0 : rom_word(addr_i >> 2);
`ifdef BOOT_ROM_PATCH_EN
            if (!m_e.err) begin
               for (int i = 3; i >= 0; i--) begin
                  if (p_valid[i] && ((p_addr[i] >> 2) == (addr_i >> 2))) m_e.data = p_data[i];
               end
            end
`endif
            exp_q[k].push_back(m_e);
         end
      end
`ifdef BOOT_ROM_PATCH_EN
      if (rst_i) begin
         for (int i = 0; i < 4; i++) p_valid[i] = 1'b0;
      end else if (patch_we_i && !m_locked) begin
         p_valid[patch_idx_i] = 1'b1;
         p_addr[patch_idx_i]  = patch_addr_i;
         p_data[patch_idx_i]  = patch_data_i;
      end
`endif
      if (rst_i)       m_locked = 1'b0;
      else if (lock_i) m_locked = 1'b1;
   end

   // ---------------------------------------------------------------- compare
   exp_t c_e;

   always @(negedge clk_i) begin
      if (cyc > 0) begin
         for (int k = 0; k < NI; k++) begin
            check($sformatf("k%0d_gnt", k), 32'(gnt[k]), 32'(req_i & ~rst_i));
            check($sformatf("k%0d_locked", k), 32'(locked[k]), 32'(m_locked));
            if ((exp_q[k].size() > 0) && (exp_q[k][0].due == cyc)) begin
               c_e = exp_q[k].pop_front();
               check($sformatf("k%0d_rvalid", k), 32'(rvalid[k]), 32'd1);
               check($sformatf("k%0d_err", k), 32'(err[k]), 32'(c_e.err));
               check($sformatf("k%0d_rdata", k), rdata[k], c_e.data);
            end else begin
               check($sformatf("k%0d_rvalid_idle", k), 32'(rvalid[k]), 32'd0);
               check($sformatf("k%0d_rdata_idle", k), rdata[k], 32'd0);
            end
         end
      end
   end

   // --------------------------------------------------------------- stimulus
   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   logic [31:0] bnd_addr [5] = '{32'h0000_1FFC, 32'h0000_2000, 32'h8000_0000, 32'h0000_0003, 32'h0000_0007};
   logic        bnd_err  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [31:0] bnd_data [5] = '{32'hB7F8_07FF, 32'h0, 32'h0, 32'hB007_0000, 32'hB006_0001};

   initial begin
      // Reset, with a request held high: no grant while in reset.
      req_i = 1'b1;
      repeat (2) cycle();
      check("rst_gnt", 32'(gnt[0]), 32'd0);
      check("rst_rvalid", 32'(rvalid[0]), 32'd0);
      check("rst_locked", 32'(locked[0]), 32'd0);
      rst_i = 1'b0;
      req_i = 1'b0;
      cycle();

      // Single read, latency 1.
      req_i  = 1'b1;
      addr_i = 32'h0;
      #1;
      check("t1_gnt", 32'(gnt[0]), 32'd1);
      cycle();
      check("t1_rvalid", 32'(rvalid[0]), 32'd1);
      check("t1_err", 32'(err[0]), 32'd0);
      check("t1_rdata", rdata[0], 32'hB007_0000);
      req_i = 1'b0;
      repeat (5) cycle();

      // Back-to-back reads on the latency-3 instance.
      req_i = 1'b1;
      addr_i = 32'h0; cycle();
      addr_i = 32'h4; cycle();
      addr_i = 32'h8; cycle();
      check("t2_rdata0", rdata[1], 32'hB007_0000);
      check("t2_rvalid0", 32'(rvalid[1]), 32'd1);
      req_i = 1'b0;
      cycle();
      check("t2_rdata1", rdata[1], 32'hB006_0001);
      cycle();
      check("t2_rdata2", rdata[1], 32'hB005_0002);
      cycle();
      check("t2_rvalid_end", 32'(rvalid[1]), 32'd0);
      repeat (3) cycle();

      // Out of range on the 1000-word instance, then its last word.
      req_i = 1'b1;
      addr_i = 32'hFA0; cycle();
      addr_i = 32'hF9C; cycle();
      req_i = 1'b0;
      cycle();
      check("t3_oor_rvalid", 32'(rvalid[1]), 32'd1);
      check("t3_oor_err", 32'(err[1]), 32'd1);
      check("t3_oor_rdata", rdata[1], 32'h0);
      cycle();
      check("t3_last_err", 32'(err[1]), 32'd0);
      check("t3_last_rdata", rdata[1], 32'hB3E0_03E7);
      repeat (3) cycle();

      // Window edges and ignored byte offsets on the latency-1 instance.
      for (int i = 0; i < 5; i++) begin
         req_i  = 1'b1;
         addr_i = bnd_addr[i];
         cycle();
         check($sformatf("bnd%0d_err", i), 32'(err[0]), 32'(bnd_err[i]));
         check($sformatf("bnd%0d_rdata", i), rdata[0], bnd_data[i]);
      end
      req_i = 1'b0;
      repeat (5) cycle();

      // Lockout.
      req_i = 1'b1; addr_i = 32'h10; lock_i = 1'b1;
      cycle();
      check("t4_lockcyc_err", 32'(err[0]), 32'd0);
      check("t4_lockcyc_rdata", rdata[0], 32'hB003_0004);
      check("t4_locked", 32'(locked[0]), 32'd1);
      lock_i = 1'b0;
      cycle();
      check("t4_locked_err", 32'(err[0]), 32'd1);
      check("t4_locked_rdata", rdata[0], 32'h0);
      test_mode_i = 1'b1;
      cycle();
      check("t4_tm_err", 32'(err[0]), 32'd0);
      check("t4_tm_rdata", rdata[0], 32'hB003_0004);
      test_mode_i = 1'b0; lock_i = 1'b1;
      cycle();
      check("t4_relock_err", 32'(err[0]), 32'd1);
      lock_i = 1'b0; req_i = 1'b0; rst_i = 1'b1;
      cycle();
      check("t4_rst_locked", 32'(locked[0]), 32'd0);
      rst_i = 1'b0; req_i = 1'b1;
      cycle();
      check("t4_unlocked_rdata", rdata[0], 32'hB003_0004);
      req_i = 1'b0;
      repeat (5) cycle();

      // Reset while two reads are in flight on the latency-4 instance.
      req_i = 1'b1;
      addr_i = 32'h0; cycle();
      addr_i = 32'h4; cycle();
      req_i = 1'b0; rst_i = 1'b1;
      cycle();
      rst_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t5_dropped%0d", i), 32'(rvalid[2]), 32'd0);
         cycle();
      end

`ifdef BOOT_ROM_PATCH_EN
      // Patch table: lowest index wins; writes ignored once locked.
      patch_we_i = 1'b1; patch_idx_i = 2'd1; patch_addr_i = 32'h20; patch_data_i = 32'hDEAD_BEEF;
      cycle();
      patch_idx_i = 2'd3; patch_data_i = 32'h1234_5678;
      cycle();
      patch_we_i = 1'b0; req_i = 1'b1; addr_i = 32'h20;
      cycle();
      check("t6_patch_rdata", rdata[0], 32'hDEAD_BEEF);
      req_i = 1'b0; lock_i = 1'b1;
      cycle();
      lock_i = 1'b0; patch_we_i = 1'b1; patch_idx_i = 2'd1; patch_data_i = 32'h0;
      cycle();
      patch_we_i = 1'b0; test_mode_i = 1'b1; req_i = 1'b1;
      cycle();
      check("t6_locked_write_ignored", rdata[0], 32'hDEAD_BEEF);
      req_i = 1'b0; test_mode_i = 1'b0;
      repeat (5) cycle();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
